// File: rtl/lt_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lt_pkg
//  Description : Shared types and constants for the LT decoder front end:
//                ingress FSM state encoding, drop-reason codes, descriptor
//                struct and a degree range helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package lt_pkg;

  // Ingress parser states, one-hot to match the decoder controller.
  typedef enum logic [4:0] {
    ST_HDR   = 5'b00001,
    ST_IDX   = 5'b00010,
    ST_DATA  = 5'b00100,
    ST_DRAIN = 5'b01000,
    ST_HOLD  = 5'b10000
  } lt_state_e;

  // Drop reasons reported on err_code.
  localparam logic [1:0] c_ERR_SHORT   = 2'd0;
  localparam logic [1:0] c_ERR_LONG    = 2'd1;
  localparam logic [1:0] c_ERR_BAD_DEG = 2'd2;
  localparam logic [1:0] c_ERR_BAD_IDX = 2'd3;

  // Default decoder geometry, used by the controller-side descriptor view.
  localparam int c_DATA_W  = 32;
  localparam int c_IDX_W   = 10;
  localparam int c_DEG_W   = 4;
  localparam int c_MAX_DEG = 8;

  // Symbol descriptor as seen by the decoder controller.
  typedef struct packed {
    logic [c_DEG_W-1:0]           degree;
    logic                         deg_one;
    logic [c_MAX_DEG*c_IDX_W-1:0] idx;
    logic [c_DATA_W-1:0]          data;
  } lt_desc_t;

  // A degree is usable when it names at least one and at most max_deg sources.
  function automatic logic lt_deg_valid(input int unsigned deg, input int unsigned max_deg);
    return (deg != 0) && (deg <= max_deg);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lt_idx_collector.sv
`default_nettype none
// ============================================================================
//  Module      : lt_idx_collector
//  Description : Neighbour index storage for one LT symbol: write counter,
//                per-slot storage cleared at each new header, and a sticky
//                out-of-range flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module lt_idx_collector
  import lt_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int IDX_W   = 10,
  parameter int MAX_DEG = 8,
  parameter int NUM_SRC = 1024,
  parameter int CNT_W   = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clr_i,
  input  logic                     wr_i,
  input  logic [DATA_W-1:0]        beat_i,
  output logic [CNT_W-1:0]         cnt_o,
  output logic [MAX_DEG*IDX_W-1:0] idx_o,
  output logic                     bad_idx_o
);

  // The range check looks at the whole beat, so stray upper bits above the
  // index field also mark the symbol as unusable.
  localparam logic [DATA_W-1:0] c_NUM_SRC = DATA_W'(NUM_SRC);

  logic [CNT_W-1:0] cnt_q;
  logic             bad_idx_q;
  logic [IDX_W-1:0] slot_q [MAX_DEG];

  // Write pointer: restarts at each header, advances once per index beat.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (wr_i)  cnt_q <= cnt_q + CNT_W'(1);
  end

  // Sticky out-of-range flag for the symbol being collected.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          bad_idx_q <= 1'b0;
    else if (clr_i)                        bad_idx_q <= 1'b0;
    else if (wr_i && (beat_i >= c_NUM_SRC)) bad_idx_q <= 1'b1;
  end

  generate
    for (genvar k = 0; k < MAX_DEG; k++) begin : g_slot
      // Slot k takes the beat when the pointer sits on it; unused slots stay 0.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                          slot_q[k] <= '0;
        else if (clr_i)                        slot_q[k] <= '0;
        else if (wr_i && cnt_q == CNT_W'(k))   slot_q[k] <= beat_i[IDX_W-1:0];
      end
      assign idx_o[k*IDX_W +: IDX_W] = slot_q[k];
    end
  endgenerate

  assign cnt_o     = cnt_q;
  assign bad_idx_o = bad_idx_q;

endmodule
`default_nettype wire

// File: rtl/lt_symbol_ingress.sv
`default_nettype none
// ============================================================================
//  Module      : lt_symbol_ingress
//  Description : AXI-Stream ingress for encoded LT symbols. Parses header,
//                neighbour indices and payload, drops malformed packets with
//                an error pulse/code, and hands one descriptor at a time to
//                the decoder controller over valid/ready.
//                Optional: LT_INGRESS_STATS_EN adds saturating packet and
//                drop counters (stat_pkt_cnt, stat_drop_cnt).
//  Revision    : 1.0 - initial release
// ============================================================================
module lt_symbol_ingress
  import lt_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int IDX_W   = 10,
  parameter int DEG_W   = 4,
  parameter int MAX_DEG = 8,
  parameter int NUM_SRC = 1024
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [DATA_W-1:0]        saxi_tdata,
  input  logic                     saxi_tvalid,
  input  logic                     saxi_tlast,
  output logic                     saxi_tready,
  output logic                     desc_valid,
  input  logic                     desc_ready,
  output logic [DEG_W-1:0]         desc_degree,
  output logic                     desc_deg_one,
  output logic [MAX_DEG*IDX_W-1:0] desc_idx,
  output logic [DATA_W-1:0]        desc_data,
  output logic                     err_pulse,
  output logic [1:0]               err_code
`ifdef LT_INGRESS_STATS_EN
  ,
  output logic [15:0]              stat_pkt_cnt,
  output logic [15:0]              stat_drop_cnt
`endif
);

  localparam int c_CNT_W = $clog2(MAX_DEG + 1);

  lt_state_e          state_q, state_d;
  logic [DEG_W-1:0]   deg_q, deg_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               err_pulse_q, err_pulse_d;
  logic [1:0]         err_code_q, err_code_d;

  logic               w_acc;
  logic               w_hs;
  logic               w_clr;
  logic               w_wr;
  logic [DEG_W-1:0]   w_hdr_deg;
  logic [c_CNT_W-1:0] w_cnt;
  logic               w_bad_idx;

  assign w_acc     = saxi_tvalid & saxi_tready;
  assign w_hs      = desc_valid & desc_ready;
  assign w_hdr_deg = saxi_tdata[DEG_W-1:0];

  lt_idx_collector #(
    .DATA_W  (DATA_W),
    .IDX_W   (IDX_W),
    .MAX_DEG (MAX_DEG),
    .NUM_SRC (NUM_SRC),
    .CNT_W   (c_CNT_W)
  ) u_idx (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr_i     (w_clr),
    .wr_i      (w_wr),
    .beat_i    (saxi_tdata),
    .cnt_o     (w_cnt),
    .idx_o     (desc_idx),
    .bad_idx_o (w_bad_idx)
  );

  // Parser state, latched descriptor fields and error reporting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_HDR;
      deg_q       <= '0;
      data_q      <= '0;
      err_pulse_q <= 1'b0;
      err_code_q  <= c_ERR_SHORT;
    end else begin
      state_q     <= state_d;
      deg_q       <= deg_d;
      data_q      <= data_d;
      err_pulse_q <= err_pulse_d;
      err_code_q  <= err_code_d;
    end
  end

  // Packet parser: decides the next state, drop reason and collector controls.
  always_comb begin
    state_d     = state_q;
    deg_d       = deg_q;
    data_d      = data_q;
    err_pulse_d = 1'b0;
    err_code_d  = err_code_q;
    w_clr       = 1'b0;
    w_wr        = 1'b0;
    case (state_q)
      ST_HDR: begin
        if (w_acc) begin
          if (!lt_deg_valid(int'(w_hdr_deg), MAX_DEG)) begin
            err_pulse_d = 1'b1;
            err_code_d  = c_ERR_BAD_DEG;
            state_d     = saxi_tlast ? ST_HDR : ST_DRAIN;
          end else if (saxi_tlast) begin
            err_pulse_d = 1'b1;
            err_code_d  = c_ERR_SHORT;
          end else begin
            deg_d   = w_hdr_deg;
            w_clr   = 1'b1;
            state_d = ST_IDX;
          end
        end
      end
      ST_IDX: begin
        if (w_acc) begin
          w_wr = 1'b1;
          if (saxi_tlast) begin
            err_pulse_d = 1'b1;
            err_code_d  = c_ERR_SHORT;
            state_d     = ST_HDR;
          end else if (int'(w_cnt) + 1 == int'(deg_q)) begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (w_acc) begin
          if (!saxi_tlast) begin
            err_pulse_d = 1'b1;
            err_code_d  = c_ERR_LONG;
            state_d     = ST_DRAIN;
          end else if (w_bad_idx) begin
            err_pulse_d = 1'b1;
            err_code_d  = c_ERR_BAD_IDX;
            state_d     = ST_HDR;
          end else begin
            data_d  = saxi_tdata;
            state_d = ST_HOLD;
          end
        end
      end
      ST_DRAIN: begin
        if (w_acc && saxi_tlast) state_d = ST_HDR;
      end
      ST_HOLD: begin
        if (desc_ready) state_d = ST_HDR;
      end
      default: state_d = ST_HDR;
    endcase
  end

  assign saxi_tready  = (state_q != ST_HOLD);
  assign desc_valid   = (state_q == ST_HOLD);
  assign desc_degree  = deg_q;
  assign desc_deg_one = (deg_q == DEG_W'(1));
  assign desc_data    = data_q;
  assign err_pulse    = err_pulse_q;
  assign err_code     = err_code_q;

`ifdef LT_INGRESS_STATS_EN
  logic [15:0] pkt_cnt_q;
  logic [15:0] drop_cnt_q;

  // Saturating counts of handed-off descriptors and dropped packets.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (w_hs && pkt_cnt_q != 16'hFFFF)         pkt_cnt_q  <= pkt_cnt_q + 16'd1;
      if (err_pulse_d && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign stat_pkt_cnt  = pkt_cnt_q;
  assign stat_drop_cnt = drop_cnt_q;
`else
  logic w_unused_hs;
  assign w_unused_hs = w_hs;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lt_symbol_ingress.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lt_symbol_ingress
//  Description : Self-checking bench for lt_symbol_ingress. A packet-level
//                reference model predicts one event per packet (descriptor or
//                drop); a monitor compares DUT outputs against the queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lt_symbol_ingress;

  localparam int DATA_W  = 32;
  localparam int IDX_W   = 10;
  localparam int DEG_W   = 4;
  localparam int MAX_DEG = 8;
  localparam int NUM_SRC = 1024;

  logic                     clk = 1'b0;
  logic                     reset_n;
  logic [DATA_W-1:0]        saxi_tdata;
  logic                     saxi_tvalid;
  logic                     saxi_tlast;
  logic                     saxi_tready;
  logic                     desc_valid;
  logic                     desc_ready;
  logic [DEG_W-1:0]         desc_degree;
  logic                     desc_deg_one;
  logic [MAX_DEG*IDX_W-1:0] desc_idx;
  logic [DATA_W-1:0]        desc_data;
  logic                     err_pulse;
  logic [1:0]               err_code;
`ifdef LT_INGRESS_STATS_EN
  logic [15:0]              stat_pkt_cnt;
  logic [15:0]              stat_drop_cnt;
`endif

  lt_symbol_ingress #(
    .DATA_W (DATA_W), .IDX_W (IDX_W), .DEG_W (DEG_W),
    .MAX_DEG(MAX_DEG), .NUM_SRC(NUM_SRC)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .saxi_tdata   (saxi_tdata),
    .saxi_tvalid  (saxi_tvalid),
    .saxi_tlast   (saxi_tlast),
    .saxi_tready  (saxi_tready),
    .desc_valid   (desc_valid),
    .desc_ready   (desc_ready),
    .desc_degree  (desc_degree),
    .desc_deg_one (desc_deg_one),
    .desc_idx     (desc_idx),
    .desc_data    (desc_data),
    .err_pulse    (err_pulse),
    .err_code     (err_code)
`ifdef LT_INGRESS_STATS_EN
    ,
    .stat_pkt_cnt (stat_pkt_cnt),
    .stat_drop_cnt(stat_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit                       is_err;
    logic [1:0]               code;
    int                       deg;
    bit                       deg_one;
    logic [MAX_DEG*IDX_W-1:0] idx;
    logic [DATA_W-1:0]        data;
  } exp_t;

  exp_t        expq[$];
  logic [32:0] pkt[$];   // bit 32 = tlast
  int          n_tests = 0;
  int          n_fail  = 0;
  int          rdy_mode;  // 0 random, 1 high, 2 low
  logic [1:0]  last_code;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Controller side: desc_ready changes just after the rising edge.
  initial begin
    desc_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       desc_ready = 1'($urandom_range(0, 1));
        1:       desc_ready = 1'b1;
        default: desc_ready = 1'b0;
      endcase
    end
  end

  // Monitor: every drop pulse and every valid descriptor cycle is matched
  // against the oldest predicted event.
  always @(negedge clk) begin
    if (reset_n) begin
      if (err_pulse) begin
        if (expq.size() == 0 || !expq[0].is_err) begin
          check("unexpected_err_pulse", 1'b1, 1'b0);
        end else begin
          check("err_code", err_code, expq[0].code);
          last_code = expq[0].code;
          void'(expq.pop_front());
        end
      end
      if (desc_valid) begin
        if (expq.size() == 0 || expq[0].is_err) begin
          check("unexpected_desc", 1'b1, 1'b0);
        end else begin
          check("desc_degree", desc_degree, expq[0].deg);
          check("desc_deg_one", desc_deg_one, expq[0].deg_one);
          check("desc_idx", desc_idx, expq[0].idx);
          check("desc_data", desc_data, expq[0].data);
          if (desc_ready) void'(expq.pop_front());
        end
      end
    end
  end

  // Packet-level reference: one predicted event and the beat that causes it.
  task automatic model(output exp_t e, output int at);
    int d;
    bit bad;
    e.is_err = 1'b1; e.code = 2'd0; e.deg = 0; e.deg_one = 1'b0;
    e.idx = '0; e.data = '0;
    d = int'(pkt[0][DEG_W-1:0]);
    if (d == 0 || d > MAX_DEG) begin e.code = 2'd2; at = 0; return; end
    if (pkt[0][32]) begin e.code = 2'd0; at = 0; return; end
    for (int i = 1; i <= d; i++) begin
      if (pkt[i][32]) begin e.code = 2'd0; at = i; return; end
    end
    at = d + 1;
    if (!pkt[d+1][32]) begin e.code = 2'd1; return; end
    bad = 1'b0;
    for (int i = 1; i <= d; i++) if (pkt[i][31:0] >= NUM_SRC) bad = 1'b1;
    if (bad) begin e.code = 2'd3; return; end
    e.is_err  = 1'b0;
    e.deg     = d;
    e.deg_one = (d == 1);
    for (int k = 0; k < d; k++) e.idx[k*IDX_W +: IDX_W] = pkt[k+1][IDX_W-1:0];
    e.data    = pkt[d+1][31:0];
  endtask

  task automatic push_beat(input logic [31:0] dat, input logic l);
    pkt.push_back({l, dat});
  endtask

  function automatic logic [31:0] rand_idx(input bit bad);
    return bad ? 32'($urandom_range(NUM_SRC, 100000)) : 32'($urandom_range(0, NUM_SRC - 1));
  endfunction

  // Present one beat from a negedge and return at the negedge after it is taken.
  task automatic drive_beat(input logic [31:0] dat, input logic l);
    bit ok;
    int guard;
    guard = 0;
    saxi_tvalid = 1'b1; saxi_tdata = dat; saxi_tlast = l;
    while (1) begin
      ok = saxi_tready;
      @(negedge clk);
      if (ok) break;
      guard++;
      if (guard > 5000) begin
        $display("FAIL beat_accept: got tready=0 expected 1 within 5000 cycles");
        $fatal(1, "stalled input");
      end
    end
    saxi_tvalid = 1'b0;
    saxi_tdata  = $urandom();
  endtask

  task automatic run_pkt(input bit gaps);
    exp_t e;
    int at;
    model(e, at);
    expq.push_back(e);
    for (int i = 0; i < pkt.size(); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) @(negedge clk);
      drive_beat(pkt[i][31:0], pkt[i][32]);
      if (i == at) begin
        if (e.is_err) check("err_pulse_latency", err_pulse, 1'b1);
        else          check("desc_valid_latency", desc_valid, 1'b1);
      end
    end
  endtask

  task automatic build_random();
    int kind, d, len, j;
    logic [31:0] hi;
    pkt.delete();
    kind = $urandom_range(0, 9);
    hi   = $urandom() & 32'hFFFF_FFF0;
    if (kind == 9) begin
      d   = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(9, 15);
      len = $urandom_range(1, 4);
      push_beat(hi | 32'(d), len == 1);
      for (int i = 1; i < len; i++) push_beat($urandom(), i == len - 1);
      return;
    end
    d = $urandom_range(1, MAX_DEG);
    if (kind == 7) begin
      j = $urandom_range(0, d);
      push_beat(hi | 32'(d), j == 0);
      for (int i = 1; i <= j; i++) push_beat(rand_idx(0), i == j);
      return;
    end
    push_beat(hi | 32'(d), 1'b0);
    j = (kind == 6) ? $urandom_range(1, d) : 0;
    for (int i = 1; i <= d; i++) push_beat(rand_idx(i == j), 1'b0);
    if (kind == 8) begin
      len = $urandom_range(1, 3);
      push_beat($urandom(), 1'b0);
      for (int i = 0; i < len; i++) push_beat($urandom(), i == len - 1);
    end else begin
      push_beat($urandom(), 1'b1);
    end
  endtask

  initial begin
    int guard;
`ifdef LT_INGRESS_STATS_EN
    logic [15:0] drops_before;
`endif
    reset_n = 1'b0; saxi_tvalid = 1'b0; saxi_tdata = '0; saxi_tlast = 1'b0;
    rdy_mode = 1; last_code = 2'd0;
    repeat (3) @(negedge clk);
    check("rst_tready", saxi_tready, 1'b1);
    check("rst_desc_valid", desc_valid, 1'b0);
    check("rst_err_pulse", err_pulse, 1'b0);
    check("rst_err_code", err_code, 2'd0);
    check("rst_desc_idx", desc_idx, '0);
    reset_n = 1'b1;
    @(negedge clk);

    // Degree 3, ready held high: one-cycle descriptor.
    pkt.delete();
    push_beat(32'd3, 0); push_beat(32'd5, 0); push_beat(32'd9, 0); push_beat(32'd1023, 0);
    push_beat(32'hA5A5_0001, 1);
    run_pkt(0);
    @(negedge clk);
    check("deg3_valid_one_cycle", desc_valid, 1'b0);
    check("deg3_tready_back", saxi_tready, 1'b1);

    // Degree 1 held by the controller for 10 cycles.
    rdy_mode = 2;
    pkt.delete();
    push_beat(32'd1, 0); push_beat(32'd77, 0); push_beat(32'h1234_5678, 1);
    run_pkt(0);
    for (int i = 0; i < 10; i++) begin
      check("hold_valid", desc_valid, 1'b1);
      check("hold_tready", saxi_tready, 1'b0);
      @(negedge clk);
    end
    rdy_mode = 1;
    @(negedge clk);
    @(negedge clk);
    check("hold_tready_after_hs", saxi_tready, 1'b1);
    check("hold_valid_after_hs", desc_valid, 1'b0);

    // Bad degree 9 then a good packet.
    pkt.delete();
    push_beat(32'd9, 0); push_beat(32'd1, 0); push_beat(32'd2, 0); push_beat(32'd3, 1);
    run_pkt(0);
    pkt.delete();
    push_beat(32'd2, 0); push_beat(32'd100, 0); push_beat(32'd200, 0); push_beat(32'hDEAD_BEEF, 1);
    run_pkt(0);

    // Short: degree 4 ending on index beat 2. Bad index 1024.
    pkt.delete();
    push_beat(32'd4, 0); push_beat(32'd1, 0); push_beat(32'd2, 1);
    run_pkt(0);
    pkt.delete();
    push_beat(32'd2, 0); push_beat(32'd1024, 0); push_beat(32'd3, 0); push_beat(32'h0BAD_0BAD, 1);
    run_pkt(0);

    // Long: payload without tlast, two extra beats, then resync.
`ifdef LT_INGRESS_STATS_EN
    drops_before = stat_drop_cnt;
`endif
    pkt.delete();
    push_beat(32'd1, 0); push_beat(32'd4, 0); push_beat(32'h1111_1111, 0);
    push_beat(32'h2222_2222, 0); push_beat(32'h3333_3333, 1);
    run_pkt(0);
`ifdef LT_INGRESS_STATS_EN
    check("stat_drop_inc", stat_drop_cnt, drops_before + 16'd1);
`endif
    pkt.delete();
    push_beat(32'd1, 0); push_beat(32'd1000, 0); push_beat(32'hCAFE_0001, 1);
    run_pkt(0);

    // Reset in the middle of index collection.
    @(negedge clk);
    drive_beat(32'd4, 0); drive_beat(32'd7, 0); drive_beat(32'd8, 0);
    reset_n = 1'b0;
    #1;
    check("midrst_tready", saxi_tready, 1'b1);
    check("midrst_valid", desc_valid, 1'b0);
    check("midrst_err_pulse", err_pulse, 1'b0);
    check("midrst_err_code", err_code, 2'd0);
    check("midrst_degree", desc_degree, 4'd0);
    check("midrst_idx", desc_idx, '0);
    check("midrst_data", desc_data, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    last_code = 2'd0;
    @(negedge clk);
    pkt.delete();
    push_beat(32'd2, 0); push_beat(32'd11, 0); push_beat(32'd22, 0); push_beat(32'h5555_AAAA, 1);
    run_pkt(0);

    // Randomised traffic with random controller backpressure.
    rdy_mode = 0;
    for (int n = 0; n < 300; n++) begin
      build_random();
      run_pkt(1);
    end
    rdy_mode = 1;

    guard = 0;
    while (expq.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("events_drained", 32'(expq.size()), 32'd0);
    check("err_code_held", err_code, last_code);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lt_symbol_ingress.md
# lt_symbol_ingress

Input stage of the LT decoder. Accepts encoded LT symbols over an AXI-Stream slave, parses each packet (degree header, neighbour indices, payload) and presents one validated symbol descriptor at a time to the decoder controller through a valid/ready port. Malformed packets are dropped and flagged, so the controller only ever sees well-formed symbols.

## Interface
Parameters:
- `DATA_W`, 32: payload symbol width and `saxi_tdata` width.
- `IDX_W`, 10: neighbour index width.
- `DEG_W`, 4: degree field width.
- `MAX_DEG`, 8: largest accepted degree; must satisfy `MAX_DEG <= 2**DEG_W - 1`.
- `NUM_SRC`, 1024: number of source symbols; a valid index is `< NUM_SRC`.

Ports:
- `clk`, in, 1: single clock; all logic on the rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `saxi_tdata`, in, DATA_W: stream data.
- `saxi_tvalid`, in, 1: stream valid.
- `saxi_tlast`, in, 1: last beat of a packet.
- `saxi_tready`, out, 1: stream ready.
- `desc_valid`, out, 1: descriptor available.
- `desc_ready`, in, 1: controller accepts the descriptor.
- `desc_degree`, out, DEG_W: symbol degree.
- `desc_deg_one`, out, 1: `desc_degree == 1`.
- `desc_idx`, out, MAX_DEG*IDX_W: neighbour indices. Slot k is bits `[k*IDX_W +: IDX_W]`. Slots at or above the degree read 0.
- `desc_data`, out, DATA_W: payload symbol.
- `err_pulse`, out, 1: one-cycle pulse when a packet is dropped.
- `err_code`, out, 2: drop reason, held until the next error. Codes: 0 short, 1 long, 2 bad degree, 3 bad index.

## Operation
- Beat accepted when `saxi_tvalid & saxi_tready`.
- Packet layout:
  - beat 0 is the header; the degree is `tdata[DEG_W-1:0]`.
  - beats 1..d carry indices in `tdata[IDX_W-1:0]`.
  - beat d+1 is the payload and must carry `tlast`.
- FSM states: HDR, IDX, DATA, DRAIN, HOLD.
  - HDR:
    - degree 0 or > MAX_DEG: err code 2. Go to DRAIN, or stay in HDR if `tlast` is set.
    - `tlast` with a valid degree: err code 0, stay in HDR.
    - otherwise latch the degree, clear the index counter and index slots, go to IDX.
  - IDX:
    - store the index in slot `cnt` and increment `cnt`.
    - index >= NUM_SRC sets a sticky `bad_idx` flag; collection continues.
    - `tlast` on any index beat: err code 0, go to HDR.
    - after beat d, go to DATA.
  - DATA:
    - without `tlast`: err code 1, go to DRAIN.
    - with `tlast` and `bad_idx` set: err code 3, go to HDR.
    - otherwise latch the payload, go to HOLD.
  - DRAIN: discard beats until a `tlast` beat is accepted, then go to HDR. No further error is reported for the same packet.
  - HOLD: `desc_valid` = 1. Descriptor fields are stable until `desc_valid & desc_ready`, then go to HDR.
- `saxi_tready` = 1 in every state except HOLD.
- `err_pulse` fires in the cycle after the offending beat is accepted. `err_code` updates in the same cycle.

## Timing
- Reset values:
  - `saxi_tready` = 1, `desc_valid` = 0, `err_pulse` = 0.
  - `err_code` = 0, `desc_*` = 0.
  - FSM in HDR, `bad_idx` = 0.
- Latency: `desc_valid` rises the cycle after the payload beat is accepted.
- Minimum gap between packets is one cycle (the HOLD cycle with `desc_ready` high). Throughput is d+2 beats in d+3 cycles.
- `desc_ready` may be held high in advance. A descriptor is consumed in exactly one handshake cycle.
- If `saxi_tvalid` is high during HOLD, the beat is not accepted; the source must hold it per AXI rules.
- Reset mid-packet: all state is cleared and the next accepted beat is parsed as a header. Upstream must be reset alongside this block.

## Configuration
- `LT_INGRESS_STATS_EN` defined: adds outputs `stat_pkt_cnt[15:0]` and `stat_drop_cnt[15:0]`.
  - `stat_pkt_cnt` counts descriptors handed off.
  - `stat_drop_cnt` counts `err_pulse` events.
  - Both saturate at 16'hFFFF and reset to 0.
- Not defined: these ports and counters do not exist. All other behaviour is identical.

## Structure
- Shared package `lt_pkg` holds:
  - the FSM state enum (one-hot, matching the decoder controller style);
  - the `err_code` localparams;
  - a descriptor struct typedef (degree, deg_one, idx array, data).
- One sub-module: `lt_idx_collector`. It covers the index counter, slot writes with zero-clear, and the `bad_idx` range check.

## Test plan
- Packet hdr=3, idx 5/9/1023, payload 32'hA5A5_0001 with `tlast`, `desc_ready` = 1. Expect:
  - `desc_valid` for 1 cycle, `desc_degree` = 3;
  - slots 0..2 = 5, 9, 1023 and slots 3..7 = 0;
  - `desc_deg_one` = 0, `desc_data` = 32'hA5A5_0001.
- Degree-1 packet with `desc_ready` held low for 10 cycles. Expect:
  - `desc_valid` and fields stable for 10 cycles, `saxi_tready` = 0;
  - `tready` returns the cycle after the handshake.
- Header degree 9 with 3 further beats, `tlast` on the last. Expect `err_pulse` with `err_code` = 2, no descriptor, and the next good packet accepted normally.
- Degree 4 with `tlast` on index beat 2: expect `err_code` = 0. Degree 2 with index 1024 (NUM_SRC = 1024): expect `err_code` = 3, no descriptor.
- Degree 1 whose payload beat lacks `tlast`, followed by 2 extra beats. Expect:
  - `err_code` = 1 and exactly one `err_pulse`;
  - the block resynchronises on the next header.
  - With `LT_INGRESS_STATS_EN`: `stat_drop_cnt` increments by 1.
- Assert `reset_n` low mid-IDX. Expect all outputs at reset values; a fresh degree-2 packet afterwards decodes correctly.
